// File: rtl/mau_controller_if.sv
// Host-side byte streams of the maintenance access controller:
// command bytes in, response bytes out, both valid/ready.
interface mau_controller_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mau_controller.sv
// Maintenance access controller: byte-command host bridge that reads and
// writes cpu IM/DM/RF while the cpu is parked, and runs/stops the cpu.
module mau_controller #(
   parameter int READ_LATENCY = 2,
   parameter int HALT_GUARD   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mau_controller_if.slave      bus,
   output logic [31:0]          mau_address_im,
   output logic [31:0]          mau_address_dm,
   output logic [31:0]          mau_address_rf,
   output logic [31:0]          mau_write_data_im,
   output logic [31:0]          mau_write_data_dm,
   output logic [31:0]          mau_write_data_rf,
   output logic                 mau_wren_im,
   output logic                 mau_wren_dm,
   output logic                 mau_wren_rf,
   input  logic [31:0]          mau_read_data_im,
   input  logic [31:0]          mau_read_data_dm,
   input  logic [31:0]          mau_read_data_rf,
   output logic                 alive,
   input  logic                 halt
);

   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int GW = $clog2(HALT_GUARD + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, DATA, WRITE, RWAIT, RESP, RUN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  tgt;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] shift;
   logic [1:0]  bcnt;
   logic [1:0]  rcnt;
   logic [LW-1:0] lat;
   logic [GW-1:0] guard;

   logic        fire;
   logic        rfire;
   logic        is_access;
   logic        is_run;
   logic        guard_done;
   logic        halt_hit;
   logic        stop_hit;
   logic        lat_done;
   logic [31:0] rd;

   assign fire       = bus.cmd_valid && bus.cmd_ready;
   assign rfire      = bus.rsp_valid && bus.rsp_ready;
   assign is_access  = bus.cmd_data inside
                       {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
   assign is_run     = bus.cmd_data == 8'h20;
   assign guard_done = guard == GW'(HALT_GUARD);
   assign halt_hit   = guard_done && halt;
   assign stop_hit   = fire && bus.cmd_data == 8'h21;
   assign lat_done   = lat == LW'(READ_LATENCY - 1);

   always_comb begin
      rd = mau_read_data_im;
      unique case (tgt)
         2'd2:    rd = mau_read_data_dm;
         2'd3:    rd = mau_read_data_rf;
         default: rd = mau_read_data_im;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (fire) begin
            if (is_access)   state_nxt = ADDR;
            else if (is_run) state_nxt = RUN;
            else             state_nxt = RESP;
         end
         ADDR:  if (fire && bcnt == 2'd3) state_nxt = wr ? DATA : RWAIT;
         DATA:  if (fire && bcnt == 2'd3) state_nxt = WRITE;
         WRITE: state_nxt = RESP;
         RWAIT: if (lat_done) state_nxt = RESP;
         RESP:  if (rfire && rcnt == 2'd0) state_nxt = IDLE;
         RUN:   if (halt_hit || stop_hit) state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = state inside {IDLE, ADDR, DATA, RUN};
      bus.rsp_valid = state == RESP;
      alive         = state == RUN;
      mau_wren_im   = state == WRITE && tgt == 2'd1;
      mau_wren_dm   = state == WRITE && tgt == 2'd2;
      mau_wren_rf   = state == WRITE && tgt == 2'd3;
   end

   assign bus.rsp_data      = shift[31:24];
   assign mau_address_im    = addr;
   assign mau_address_dm    = addr;
   assign mau_address_rf    = addr;
   assign mau_write_data_im = wdata;
   assign mau_write_data_dm = wdata;
   assign mau_write_data_rf = wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt   <= '0;
         wr    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         shift <= '0;
         bcnt  <= '0;
         rcnt  <= '0;
         lat   <= '0;
         guard <= '0;
      end else begin
         unique case (state)
            IDLE: if (fire) begin
               tgt   <= bus.cmd_data[1:0];
               wr    <= ~bus.cmd_data[4];
               bcnt  <= '0;
               lat   <= '0;
               guard <= '0;
               if (!is_access && !is_run) begin
                  shift <= {8'hEE, 24'h0};
                  rcnt  <= 2'd0;
               end
            end
            ADDR: if (fire) begin
               addr <= {addr[23:0], bus.cmd_data};
               bcnt <= bcnt + 2'd1;
            end
            DATA: if (fire) begin
               wdata <= {wdata[23:0], bus.cmd_data};
               bcnt  <= bcnt + 2'd1;
            end
            WRITE: begin
               shift <= {8'hA5, 24'h0};
               rcnt  <= 2'd0;
            end
            RWAIT: begin
               if (lat_done) begin
                  shift <= rd;
                  rcnt  <= 2'd3;
                  lat   <= '0;
               end else begin
                  lat <= lat + LW'(1);
               end
            end
            RESP: if (rfire) begin
               shift <= {shift[23:0], 8'h0};
               rcnt  <= rcnt - 2'd1;
            end
            RUN: begin
               // halt outranks a stop byte arriving in the same cycle
               if (halt_hit) begin
                  shift <= {8'h48, 24'h0};
                  rcnt  <= 2'd0;
               end else if (stop_hit) begin
                  shift <= {8'h53, 24'h0};
                  rcnt  <= 2'd0;
               end
               if (!guard_done) guard <= guard + GW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
